// File: rtl/mc_control.sv
// mc_control: multicycle RV32I control FSM sequencing PC, IR, ALU, register file and unified memory port.
module mc_control #(
    parameter int RESET_TO_FETCH = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       mem_req,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic       illegal,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECUTER, ALUWB, EXECUTEI, JAL, BEQ, TRAP
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    // Only the fetch-on-reset flavour exists; anything else parks the FSM in TRAP.
    localparam state_t RST_STATE = (RESET_TO_FETCH == 1) ? FETCH : TRAP;

    state_t cur, nxt;
    logic f3_ok;
    logic [2:0] alu_fn;

    assign state = cur;
    assign f3_ok = (funct3 == 3'b000) || (funct3 == 3'b010) || (funct3 == 3'b110) || (funct3 == 3'b111);
    assign alu_fn = (funct3 == 3'b000) ? ((cur == EXECUTER && funct7b5) ? 3'b001 : 3'b000) :
                    (funct3 == 3'b010) ? 3'b101 :
                    (funct3 == 3'b110) ? 3'b011 : 3'b010;

    always_ff @(posedge clk or posedge rst)
        if (rst) cur <= RST_STATE;
        else cur <= nxt;

    always_comb begin
        nxt = cur;
        pc_write = 1'b0;
        ir_write = 1'b0;
        adr_src = 1'b0;
        mem_write = 1'b0;
        mem_req = 1'b0;
        reg_write = 1'b0;
        result_src = 2'b00;
        alu_src_a = 2'b00;
        alu_src_b = 2'b00;
        imm_src = 2'b00;
        alu_control = 3'b000;
        illegal = 1'b0;
        case (cur)
            FETCH: begin
                mem_req = 1'b1;
                alu_src_b = 2'b10;
                result_src = 2'b10;
                ir_write = mem_ready;
                pc_write = mem_ready;
                nxt = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src = (opcode == OP_SW) ? 2'b01 : (opcode == OP_BEQ) ? 2'b10 : (opcode == OP_JAL) ? 2'b11 : 2'b00;
                nxt = (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                      (opcode == OP_R && f3_ok) ? EXECUTER :
                      (opcode == OP_I && f3_ok) ? EXECUTEI :
                      (opcode == OP_JAL) ? JAL :
                      (opcode == OP_BEQ && funct3 == 3'b000) ? BEQ : TRAP;
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src = (opcode == OP_SW) ? 2'b01 : 2'b00;
                nxt = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                nxt = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write = 1'b1;
                nxt = FETCH;
            end
            MEMWRITE: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                mem_write = 1'b1;
                nxt = mem_ready ? FETCH : MEMWRITE;
            end
            EXECUTER, EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = (cur == EXECUTEI) ? 2'b01 : 2'b00;
                alu_control = alu_fn;
                nxt = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                nxt = FETCH;
            end
            // ALU forms oldPC+4 for the link while ALUOut carries the target latched in DECODE.
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                imm_src = 2'b11;
                pc_write = 1'b1;
                nxt = ALUWB;
            end
            BEQ: begin
                alu_src_a = 2'b10;
                alu_control = 3'b001;
                imm_src = 2'b10;
                pc_write = zero;
                nxt = FETCH;
            end
            default: begin
                illegal = 1'b1;
                nxt = TRAP;
            end
        endcase
        if (rst) begin
            pc_write = 1'b0;
            ir_write = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            mem_req = 1'b0;
        end
    end
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed vectors for the multicycle control FSM.
module tb_mc_control;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] ir = 32'h002081B3;
    logic zero = 1'b0;
    logic mem_ready = 1'b1;
    logic pc_write, ir_write, adr_src, mem_write, mem_req, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic [3:0] state;
    int vec = 0;
    int errs = 0;
    int cyc = 0;

    mc_control dut (
        .clk(clk), .rst(rst), .opcode(ir[6:0]), .funct3(ir[14:12]), .funct7b5(ir[30]),
        .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
        .adr_src(adr_src), .mem_write(mem_write), .mem_req(mem_req), .reg_write(reg_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_src(imm_src), .alu_control(alu_control), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
        cyc++;
    endtask

    function automatic logic [4:0] ens();
        return {pc_write, ir_write, mem_write, reg_write, mem_req};
    endfunction

    initial begin
        #12;
        check("rst_state", state, 0);
        check("rst_enables", ens(), 0);
        check("rst_illegal", illegal, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("add_fetch_state", state, 0);
        check("add_fetch_en", ens(), 5'b11001);
        check("add_fetch_srcb", alu_src_b, 2'b10);
        check("add_fetch_res", result_src, 2'b10);
        tick;
        check("add_decode", state, 1);
        check("add_decode_srca", alu_src_a, 2'b01);
        tick;
        check("add_exec", state, 6);
        check("add_aluop", alu_control, 3'b000);
        check("add_exec_rw", reg_write, 0);
        tick;
        check("add_aluwb", state, 7);
        check("add_aluwb_rw", reg_write, 1);
        tick;
        check("add_done", state, 0);

        ir = 32'h402081B3;
        tick;
        tick;
        check("sub_exec", state, 6);
        check("sub_aluop", alu_control, 3'b001);
        tick;
        tick;
        check("sub_done", state, 0);

        ir = 32'h00002083;
        cyc = 1;
        tick;
        tick;
        check("lw_memadr", state, 2);
        check("lw_imm", imm_src, 2'b00);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("lw_wait_state", state, 3);
            check("lw_wait_adr", adr_src, 1);
            check("lw_wait_req", mem_req, 1);
        end
        tick;
        mem_ready = 1'b1;
        check("lw_ready_state", state, 3);
        tick;
        check("lw_memwb", state, 4);
        check("lw_memwb_rw", reg_write, 1);
        check("lw_memwb_res", result_src, 2'b01);
        tick;
        check("lw_done", state, 0);
        check("lw_cycles", cyc - 1, 8);

        ir = 32'h00102023;
        cyc = 1;
        tick;
        tick;
        check("sw_memadr", state, 2);
        check("sw_imm", imm_src, 2'b01);
        mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick;
            check("sw_wait_state", state, 5);
            check("sw_wait_mw", mem_write, 1);
            check("sw_wait_rw", reg_write, 0);
        end
        tick;
        mem_ready = 1'b1;
        #1;
        check("sw_ready_mw", mem_write, 1);
        tick;
        check("sw_done", state, 0);
        check("sw_done_mw", mem_write, 0);
        check("sw_cycles", cyc - 1, 6);

        ir = 32'h00000063;
        zero = 1'b1;
        cyc = 1;
        tick;
        check("beq_dec_imm", imm_src, 2'b10);
        tick;
        check("beq_state", state, 10);
        check("beq_taken_pcw", pc_write, 1);
        check("beq_imm", imm_src, 2'b10);
        check("beq_aluop", alu_control, 3'b001);
        tick;
        check("beq_cycles", (state == 0) ? cyc - 1 : 0, 3);
        zero = 1'b0;
        cyc = 1;
        tick;
        tick;
        check("beq_nt_pcw", pc_write, 0);
        tick;
        check("beq_nt_cycles", (state == 0) ? cyc - 1 : 0, 3);

        ir = 32'h0000006F;
        tick;
        check("jal_decode", state, 1);
        tick;
        check("jal_state", state, 9);
        check("jal_imm", imm_src, 2'b11);
        check("jal_pcw", pc_write, 1);
        tick;
        check("jal_aluwb", state, 7);
        tick;
        check("jal_done", state, 0);

        ir = 32'hFFFFFFFF;
        tick;
        for (int i = 0; i < 20; i++) begin
            tick;
            check("trap_state", state, 11);
            check("trap_illegal", illegal, 1);
            check("trap_en", ens(), 0);
        end
        #1;
        rst = 1'b1;
        #1;
        check("trap_rst_state", state, 0);
        check("trap_rst_illegal", illegal, 0);
        check("trap_rst_en", ens(), 0);

        ir = 32'h000011B3;
        @(negedge clk);
        rst = 1'b0;
        tick;
        tick;
        check("badf3_trap", state, 11);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
